// File: rtl/butterfly_pipe_if.sv
// Handshake and data bundle between the FFT stage controller (master)
// and the pipelined butterfly (slave).
interface butterfly_pipe_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int FACTOR_WIDTH = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [2*DATA_WIDTH-1:0]   in_x0;
  logic [2*DATA_WIDTH-1:0]   in_x1;
  logic [2*FACTOR_WIDTH-1:0] in_w;
  logic                      in_mode;
  logic                      in_scale;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*DATA_WIDTH-1:0]   out_x0;
  logic [2*DATA_WIDTH-1:0]   out_x1;
  logic                      out_last;
  logic                      ovf_flag;
  logic                      ovf_clr;

  modport master (
    output in_valid, in_x0, in_x1, in_w, in_mode, in_scale, in_last,
    output out_ready, ovf_clr,
    input  in_ready, out_valid, out_x0, out_x1, out_last, ovf_flag
  );

  modport slave (
    input  in_valid, in_x0, in_x1, in_w, in_mode, in_scale, in_last,
    input  out_ready, ovf_clr,
    output in_ready, out_valid, out_x0, out_x1, out_last, ovf_flag
  );
endinterface

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 butterfly (DIT or DIF per transaction) with rounding,
// optional divide-by-2 scaling, saturation and a sticky overflow flag.
// One global advance enable stalls every stage together under backpressure.
module butterfly_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int FACTOR_WIDTH = 16,
  parameter int FRAC_BITS    = 14,
  parameter bit ROUNDING     = 1'b1,
  parameter bit SATURATE     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  butterfly_pipe_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int FW = FACTOR_WIDTH;
  localparam int AW = DW + 1;                 // a / d width, lossless sum
  localparam int PW = AW + FW;                // one real product
  localparam int SW = PW + 1;                 // sum/difference of two products
  localparam int QW = SW - FRAC_BITS;         // product after the fraction shift
  localparam int YW = (QW + 1 > DW + 2) ? QW + 1 : DW + 2;  // output arithmetic

  localparam logic signed [SW-1:0] RND_P = SW'(ROUNDING) << (FRAC_BITS - 1);
  localparam logic signed [YW-1:0] RND_Y = YW'(ROUNDING);

  // Forms one output component before reduction: DIT y0/y1 = a +/- p,
  // DIF y0 = a, y1 = p; then the optional rounded halving.
  function automatic logic signed [YW-1:0] y_calc(
    input logic signed [AW-1:0] a,
    input logic signed [QW-1:0] p,
    input logic                 is_y1,
    input logic                 mode,
    input logic                 scale
  );
    logic signed [YW-1:0] y;
    logic signed [YW-1:0] t;
    if (mode) y = is_y1 ? YW'(p) : YW'(a);
    else      y = is_y1 ? YW'(a) - YW'(p) : YW'(a) + YW'(p);
    t = y + RND_Y;
    if (scale) y = {t[YW-1], t[YW-1:1]};
    return y;
  endfunction

  // Reduces to DW bits; bit DW of the result reports an out-of-range value,
  // which is flagged whether the value is clamped or wrapped.
  function automatic logic [DW:0] reduce(input logic signed [YW-1:0] y);
    logic          ovf;
    logic [DW-1:0] r;
    ovf = !((&y[YW-1:DW-1]) || !(|y[YW-1:DW-1]));
    if (ovf && SATURATE) r = y[YW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else                 r = y[DW-1:0];
    return {ovf, r};
  endfunction

  logic w_adv;

  // Stage 1 inputs
  logic signed [DW-1:0] w_x0_re, w_x0_im, w_x1_re, w_x1_im;
  logic signed [FW-1:0] w_w_re, w_w_im;
  logic signed [AW-1:0] w_a_re, w_a_im, w_d_re, w_d_im;

  logic                 r_s1_valid, r_s1_mode, r_s1_scale, r_s1_last;
  logic signed [AW-1:0] r_s1_a_re, r_s1_a_im, r_s1_d_re, r_s1_d_im;
  logic signed [FW-1:0] r_s1_w_re, r_s1_w_im;

  // Stage 2 complex multiply
  logic signed [PW-1:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [SW-1:0] w_sum_re, w_sum_im;

  logic                 r_s2_valid, r_s2_mode, r_s2_scale, r_s2_last;
  logic signed [AW-1:0] r_s2_a_re, r_s2_a_im;
  logic signed [SW-1:0] r_s2_sum_re, r_s2_sum_im;

  // Stage 3 shift, combine, reduce
  logic signed [SW-1:0] w_rs_re, w_rs_im;
  logic signed [QW-1:0] w_p_re, w_p_im;
  logic [DW:0]          w_y0_re, w_y0_im, w_y1_re, w_y1_im;
  logic                 w_ovf;

  logic                 r_out_valid, r_out_last, r_ovf;
  logic [2*DW-1:0]      r_out_x0, r_out_x1;

  assign w_adv        = bus.out_ready | ~r_out_valid;
  assign bus.in_ready = w_adv;

  assign w_x0_re = bus.in_x0[2*DW-1:DW];
  assign w_x0_im = bus.in_x0[DW-1:0];
  assign w_x1_re = bus.in_x1[2*DW-1:DW];
  assign w_x1_im = bus.in_x1[DW-1:0];
  assign w_w_re  = bus.in_w[2*FW-1:FW];
  assign w_w_im  = bus.in_w[FW-1:0];

  assign w_a_re = bus.in_mode ? AW'(w_x0_re) + AW'(w_x1_re) : AW'(w_x0_re);
  assign w_a_im = bus.in_mode ? AW'(w_x0_im) + AW'(w_x1_im) : AW'(w_x0_im);
  assign w_d_re = bus.in_mode ? AW'(w_x0_re) - AW'(w_x1_re) : AW'(w_x1_re);
  assign w_d_im = bus.in_mode ? AW'(w_x0_im) - AW'(w_x1_im) : AW'(w_x1_im);

  assign w_rr     = PW'(r_s1_d_re) * PW'(r_s1_w_re);
  assign w_ii     = PW'(r_s1_d_im) * PW'(r_s1_w_im);
  assign w_ri     = PW'(r_s1_d_re) * PW'(r_s1_w_im);
  assign w_ir     = PW'(r_s1_d_im) * PW'(r_s1_w_re);
  assign w_sum_re = SW'(w_rr) - SW'(w_ii);
  assign w_sum_im = SW'(w_ri) + SW'(w_ir);

  // Taking the top bits after adding the rounding constant is the arithmetic shift.
  assign w_rs_re = r_s2_sum_re + RND_P;
  assign w_rs_im = r_s2_sum_im + RND_P;
  assign w_p_re  = w_rs_re[SW-1:FRAC_BITS];
  assign w_p_im  = w_rs_im[SW-1:FRAC_BITS];

  assign w_y0_re = reduce(y_calc(r_s2_a_re, w_p_re, 1'b0, r_s2_mode, r_s2_scale));
  assign w_y0_im = reduce(y_calc(r_s2_a_im, w_p_im, 1'b0, r_s2_mode, r_s2_scale));
  assign w_y1_re = reduce(y_calc(r_s2_a_re, w_p_re, 1'b1, r_s2_mode, r_s2_scale));
  assign w_y1_im = reduce(y_calc(r_s2_a_im, w_p_im, 1'b1, r_s2_mode, r_s2_scale));
  assign w_ovf   = w_y0_re[DW] | w_y0_im[DW] | w_y1_re[DW] | w_y1_im[DW];

  assign bus.out_valid = r_out_valid;
  assign bus.out_x0    = r_out_x0;
  assign bus.out_x1    = r_out_x1;
  assign bus.out_last  = r_out_last;
  assign bus.ovf_flag  = r_ovf;

  // Control path and output stage: valids, results and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x0    <= '0;
      r_out_x1    <= '0;
      r_out_last  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_adv) begin
        r_s1_valid  <= bus.in_valid;
        r_s2_valid  <= r_s1_valid;
        r_out_valid <= r_s2_valid;
        r_out_x0    <= {w_y0_re[DW-1:0], w_y0_im[DW-1:0]};
        r_out_x1    <= {w_y1_re[DW-1:0], w_y1_im[DW-1:0]};
        r_out_last  <= r_s2_last;
      end
      // NOTE: the set term is OR-ed after the clear so a same-cycle overflow wins.
      r_ovf <= (r_ovf & ~bus.ovf_clr) | (w_adv & r_s2_valid & w_ovf);
    end
  end

  // Datapath stages 1 and 2; everything holds while the pipe is stalled.
  // NOTE: no reset here on purpose - these values are only consumed when the
  // matching valid bit (which is reset) says they are meaningful.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_a_re   <= w_a_re;
      r_s1_a_im   <= w_a_im;
      r_s1_d_re   <= w_d_re;
      r_s1_d_im   <= w_d_im;
      r_s1_w_re   <= w_w_re;
      r_s1_w_im   <= w_w_im;
      r_s1_mode   <= bus.in_mode;
      r_s1_scale  <= bus.in_scale;
      r_s1_last   <= bus.in_last;
      r_s2_a_re   <= r_s1_a_re;
      r_s2_a_im   <= r_s1_a_im;
      r_s2_sum_re <= w_sum_re;
      r_s2_sum_im <= w_sum_im;
      r_s2_mode   <= r_s1_mode;
      r_s2_scale  <= r_s1_scale;
      r_s2_last   <= r_s1_last;
    end
  end
endmodule
